fir_sterowanie_fsm: RTL and testbench
=====================================

Name: fir_sterowanie_fsm

Overview:
- Control FSM that drives the FIR sample-address counter and sequences one filter run.
- Issues the counter's configure, reset and increment strobes, and consumes its full flag.
- For each sample it clears the MAC, walks the coefficient index, waits out the MAC pipeline, then writes the result.
- Sits between the register block (start, sizes) and the FIR datapath (MAC, result RAM).

Parameters:
- WSP_W, 6: width of the coefficient count and of the coefficient address.
- MAC_LAT, 2: MAC pipeline latency in cycles, range 0..15.

Ports:
- clk_b  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle run request; ignored unless in IDLE
- ile_probek  in  14  number of samples; held stable during a run
- ile_wsp  in  WSP_W  number of coefficients; latched in LOAD
- licznik_full  in  1  full flag from the counter
- A_probki_FIR  in  13  current sample address from the counter
- FSM_zapisz_probki  out  1  counter: latch ile_probek
- FSM_reset_licznik  out  1  counter: clear address
- FSM_nowa_probka  out  1  counter: advance address
- A_wsp  out  WSP_W  coefficient index for the MAC
- mac_clr  out  1  clear the accumulator
- mac_en  out  1  accumulate one tap
- we_wyn  out  1  write strobe for the result RAM
- A_wyn  out  13  result RAM address
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle end-of-run pulse

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk_b. State goes to IDLE. All outputs are 0, and internal registers k, wsp_q and lat_cnt are 0.
- Output timing: all outputs are registered, or decoded from the registered state only. There is no combinational path from any input to any output.
- IDLE: start=1 moves to LOAD.
- LOAD (1 cycle):
  - FSM_zapisz_probki=1 and FSM_reset_licznik=1; wsp_q<=ile_wsp.
  - If ile_probek==0 or ile_wsp==0, go to DONE. No MAC, write or increment strobes are issued.
  - Otherwise go to CLR.
- CLR (1 cycle): mac_clr=1, k<=0; go to MAC.
- MAC (wsp_q cycles):
  - mac_en=1, A_wsp=k, k<=k+1.
  - When k==wsp_q-1, go to WAIT, with lat_cnt<=MAC_LAT.
  - If MAC_LAT==0, go straight to WRITE instead.
- WAIT (MAC_LAT cycles): lat_cnt decrements; at lat_cnt==1 go to WRITE.
- WRITE (1 cycle): we_wyn=1, A_wyn=A_probki_FIR; go to NEXT.
- NEXT (1 cycle): FSM_nowa_probka=1; go to CHECK.
- CHECK (1 cycle):
  - licznik_full is sampled only here, one cycle after the FSM_nowa_probka pulse.
  - licznik_full=1 goes to DONE; 0 goes to CLR.
  - The counter does not clear licznik_full on FSM_reset_licznik. A stale 1 left over from the previous run must therefore be ignored in every other state.
- DONE (1 cycle): done=1; go to IDLE.
- Cycle counts:
  - Per sample: wsp_q + MAC_LAT + 4 cycles.
  - Whole run: 1 (LOAD) + N*(wsp_q+MAC_LAT+4) + 1 (DONE).
- ile_probek==1: exactly one sample is processed. The first FSM_nowa_probka sets licznik_full.
- ile_wsp==1: MAC lasts 1 cycle, with A_wsp=0.
- Sizes changed mid-run: wsp_q is unaffected. ile_probek must not change; if it does, behaviour is undefined.
- start while busy: ignored, with no queuing.
- rst_n asserted mid-run: immediate return to IDLE and all outputs 0. No done pulse.

Optional Feature:
- Macro: FIR_IRQ_EN.
- With the macro defined:
  - Adds input irq_ack (1 bit) and output irq (1 bit).
  - irq is a sticky flag, set in the cycle after DONE and cleared by irq_ack.
  - If set and irq_ack coincide, set wins. Reset value is 0.
- Without the macro: the irq and irq_ack ports do not exist, and behaviour is otherwise identical.

Test Plan:
- ile_probek=4, ile_wsp=3, MAC_LAT=2, start pulse → counter model produces we_wyn at A_wyn=0,1,2,3. Each sample gets 3 mac_en cycles with A_wsp=0,1,2. done arrives 38 cycles after LOAD begins, and FSM_nowa_probka pulses exactly 4 times.
- ile_probek=1, ile_wsp=1, MAC_LAT=0 → one write at A_wyn=0, then done. Per-sample time is 5 cycles.
- ile_probek=0, start → LOAD then DONE; mac_en, we_wyn and FSM_nowa_probka never assert.
- Back-to-back runs: second run with ile_probek=3 while licznik_full is still 1 from the first run → the stale flag is ignored and 3 writes occur.
- start re-asserted during MAC, then rst_n pulsed in WAIT → second start ignored. After reset, busy=0, done never pulses, and all outputs are 0.
- FIR_IRQ_EN defined: run completes → irq=1 until irq_ack. irq_ack held while done fires → irq=1.

Source files
------------

// File: rtl/fir_sterowanie_fsm_if.sv
// Signal bundle between the FIR control FSM and its neighbours: the register
// block (start, sizes), the sample-address counter (strobes, full, address)
// and the FIR datapath (MAC controls, result RAM write port).
// The master modport is the FSM side; the slave modport is the environment.
// When FIR_IRQ_EN is defined the bundle also carries irq/irq_ack.
interface fir_sterowanie_fsm_if #(
    parameter int WSP_W = 6
);
    // Register block -> FSM
    logic             start;
    logic [13:0]      ile_probek;
    logic [WSP_W-1:0] ile_wsp;

    // Sample-address counter <-> FSM
    logic             licznik_full;
    logic [12:0]      A_probki_FIR;
    logic             FSM_zapisz_probki;
    logic             FSM_reset_licznik;
    logic             FSM_nowa_probka;

    // FSM -> MAC / result RAM
    logic [WSP_W-1:0] A_wsp;
    logic             mac_clr;
    logic             mac_en;
    logic             we_wyn;
    logic [12:0]      A_wyn;

    // Status
    logic             busy;
    logic             done;

`ifdef FIR_IRQ_EN
    logic             irq_ack;
    logic             irq;

    modport master (
        input  start, ile_probek, ile_wsp, licznik_full, A_probki_FIR, irq_ack,
        output FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
               A_wsp, mac_clr, mac_en, we_wyn, A_wyn, busy, done, irq
    );

    modport slave (
        output start, ile_probek, ile_wsp, licznik_full, A_probki_FIR, irq_ack,
        input  FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
               A_wsp, mac_clr, mac_en, we_wyn, A_wyn, busy, done, irq
    );
`else
    modport master (
        input  start, ile_probek, ile_wsp, licznik_full, A_probki_FIR,
        output FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
               A_wsp, mac_clr, mac_en, we_wyn, A_wyn, busy, done
    );

    modport slave (
        output start, ile_probek, ile_wsp, licznik_full, A_probki_FIR,
        input  FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
               A_wsp, mac_clr, mac_en, we_wyn, A_wyn, busy, done
    );
`endif

endinterface

// File: rtl/fir_sterowanie_fsm.sv
// FIR run sequencer. One run: LOAD configures and clears the sample-address
// counter, then for every sample CLR -> MAC (one cycle per coefficient) ->
// WAIT (MAC pipeline drain) -> WRITE (result RAM) -> NEXT (advance counter)
// -> CHECK (sample the counter's full flag), and finally a one-cycle DONE.
// Every output is either a flop or a decode of the registered state, so no
// input reaches an output combinationally.
// Optional feature: define FIR_IRQ_EN to add a sticky irq flag with irq_ack.
// WSP_W must match the WSP_W of the connected fir_sterowanie_fsm_if.
module fir_sterowanie_fsm #(
    parameter int WSP_W   = 6,
    parameter int MAC_LAT = 2   // 0..15
) (
    input  logic                  clk_b,
    input  logic                  rst_n,
    fir_sterowanie_fsm_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_MAC,
        S_WAIT,
        S_WRITE,
        S_NEXT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0]       LAT_INIT = 4'(MAC_LAT);
    localparam logic [WSP_W-1:0] WSP_ONE  = WSP_W'(1);

    state_t           state_q, state_d;
    logic [WSP_W-1:0] wsp_q, wsp_d;         // coefficient count latched in LOAD
    logic [WSP_W-1:0] k_q, k_d;             // coefficient index driven onto A_wsp
    logic [3:0]       lat_cnt_q, lat_cnt_d; // remaining MAC pipeline cycles
    logic [12:0]      a_wyn_q, a_wyn_d;     // result address for the WRITE cycle

    logic             mac_last;

    // Decoded strobes (functions of state_q only).
    logic             zapisz_probki;
    logic             reset_licznik;
    logic             nowa_probka;
    logic             clr_acc;
    logic             en_acc;
    logic             we;
    logic             busy_s;
    logic             done_s;

    // Last tap of the current sample.
    assign mac_last = (k_q == (wsp_q - WSP_ONE));

    // State register; reset drops straight back to IDLE from any state.
    // NOTE: flops are written with non-blocking (<=) so every register samples
    // the values present before the edge, independent of block ordering.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode. licznik_full is looked at only in CHECK: the counter
    // keeps a stale 1 across runs until its first advance, so any other state
    // must ignore it.
    always_comb begin
        // NOTE: state_d gets a default before the case so that every path
        // assigns it and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if ((bus.ile_probek == '0) || (bus.ile_wsp == '0)) state_d = S_DONE;
                else                                                state_d = S_CLR;
            end
            S_CLR: begin
                state_d = S_MAC;
            end
            S_MAC: begin
                if (mac_last) state_d = (MAC_LAT == 0) ? S_WRITE : S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt_q == 4'd1) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = bus.licznik_full ? S_DONE : S_CLR;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        zapisz_probki = 1'b0;
        reset_licznik = 1'b0;
        nowa_probka   = 1'b0;
        clr_acc       = 1'b0;
        en_acc        = 1'b0;
        we            = 1'b0;
        done_s        = 1'b0;
        busy_s        = (state_q != S_IDLE);
        unique case (state_q)
            S_LOAD: begin
                zapisz_probki = 1'b1;
                reset_licznik = 1'b1;
            end
            S_CLR:   clr_acc     = 1'b1;
            S_MAC:   en_acc      = 1'b1;
            S_WRITE: we          = 1'b1;
            S_NEXT:  nowa_probka = 1'b1;
            S_DONE:  done_s      = 1'b1;
            default: ;
        endcase
    end

    // Run registers: coefficient count, tap index, latency countdown and the
    // captured result address.
    always_comb begin
        wsp_d     = wsp_q;
        k_d       = k_q;
        lat_cnt_d = lat_cnt_q;
        a_wyn_d   = a_wyn_q;

        unique case (state_q)
            S_LOAD: begin
                wsp_d = bus.ile_wsp;
            end
            S_CLR: begin
                k_d = '0;
            end
            S_MAC: begin
                k_d = k_q + WSP_ONE;
                if (mac_last) lat_cnt_d = LAT_INIT;
            end
            S_WAIT: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
            end
            default: ;
        endcase

        // The counter moves only on FSM_nowa_probka (NEXT), so the address seen
        // on the way into WRITE equals the one during WRITE; registering it
        // keeps A_wyn free of any input-to-output path.
        if (state_d == S_WRITE) a_wyn_d = bus.A_probki_FIR;
    end

    // Run register flops.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            wsp_q     <= '0;
            k_q       <= '0;
            lat_cnt_q <= '0;
            a_wyn_q   <= '0;
        end else begin
            wsp_q     <= wsp_d;
            k_q       <= k_d;
            lat_cnt_q <= lat_cnt_d;
            a_wyn_q   <= a_wyn_d;
        end
    end

    assign bus.FSM_zapisz_probki = zapisz_probki;
    assign bus.FSM_reset_licznik = reset_licznik;
    assign bus.FSM_nowa_probka   = nowa_probka;
    assign bus.mac_clr           = clr_acc;
    assign bus.mac_en            = en_acc;
    assign bus.we_wyn            = we;
    assign bus.busy              = busy_s;
    assign bus.done              = done_s;
    assign bus.A_wsp             = k_q;
    assign bus.A_wyn             = a_wyn_q;

`ifdef FIR_IRQ_EN
    logic irq_q, irq_d;

    // Sticky end-of-run flag: set the cycle after DONE, cleared by irq_ack;
    // a set in the same cycle as an acknowledge wins.
    always_comb begin
        irq_d = irq_q;
        if (state_q == S_DONE) irq_d = 1'b1;
        else if (bus.irq_ack)  irq_d = 1'b0;
    end

    // irq flop.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_fir_sterowanie_fsm.sv
// Bench for fir_sterowanie_fsm. Two instances run side by side on identical
// stimulus, one with MAC_LAT=2 and one with MAC_LAT=0. A behavioural counter
// model feeds each instance, and a monitor reduces every run to counts and
// cycle offsets that are compared with values derived from the run rules:
// per sample W+L+4 cycles, run length 2 + N*(W+L+4), A_wsp walking 0..W-1,
// writes at addresses 0..N-1. FIR_IRQ_EN adds the irq checks.
module tb_fir_sterowanie_fsm;

    localparam int WSP_W = 6;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic             clk_b      = 1'b0;
    logic             rst_n      = 1'b0;
    logic             start      = 1'b0;
    logic [13:0]      ile_probek = '0;
    logic [WSP_W-1:0] ile_wsp    = '0;
`ifdef FIR_IRQ_EN
    logic             irq_ack    = 1'b0;
`endif

    always #5 clk_b = ~clk_b;

    fir_sterowanie_fsm_if #(.WSP_W(WSP_W)) bus0 ();
    fir_sterowanie_fsm_if #(.WSP_W(WSP_W)) bus1 ();

    fir_sterowanie_fsm #(.WSP_W(WSP_W), .MAC_LAT(LAT_A)) dut0 (
        .clk_b (clk_b),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    fir_sterowanie_fsm #(.WSP_W(WSP_W), .MAC_LAT(LAT_B)) dut1 (
        .clk_b (clk_b),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Observed outputs, indexed by instance.
    logic             o_zap [2];
    logic             o_rl  [2];
    logic             o_nowa[2];
    logic             o_clr [2];
    logic             o_en  [2];
    logic             o_we  [2];
    logic             o_busy[2];
    logic             o_done[2];
    logic [WSP_W-1:0] o_awsp[2];
    logic [12:0]      o_awyn[2];

    assign o_zap[0]  = bus0.FSM_zapisz_probki;  assign o_zap[1]  = bus1.FSM_zapisz_probki;
    assign o_rl[0]   = bus0.FSM_reset_licznik;  assign o_rl[1]   = bus1.FSM_reset_licznik;
    assign o_nowa[0] = bus0.FSM_nowa_probka;    assign o_nowa[1] = bus1.FSM_nowa_probka;
    assign o_clr[0]  = bus0.mac_clr;            assign o_clr[1]  = bus1.mac_clr;
    assign o_en[0]   = bus0.mac_en;             assign o_en[1]   = bus1.mac_en;
    assign o_we[0]   = bus0.we_wyn;             assign o_we[1]   = bus1.we_wyn;
    assign o_busy[0] = bus0.busy;               assign o_busy[1] = bus1.busy;
    assign o_done[0] = bus0.done;               assign o_done[1] = bus1.done;
    assign o_awsp[0] = bus0.A_wsp;              assign o_awsp[1] = bus1.A_wsp;
    assign o_awyn[0] = bus0.A_wyn;              assign o_awyn[1] = bus1.A_wyn;

    // Counter model: address cleared by FSM_reset_licznik, advanced by
    // FSM_nowa_probka; full is refreshed on each advance and otherwise kept,
    // so a 1 from the previous run survives into the next one.
    logic [12:0] cnt_addr[2];
    logic        cnt_full[2];
    logic [13:0] cnt_n   [2];

    always @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                cnt_addr[d] <= '0;
                cnt_full[d] <= 1'b0;
                cnt_n[d]    <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (o_zap[d]) cnt_n[d] <= ile_probek;
                if (o_rl[d]) begin
                    cnt_addr[d] <= '0;
                end else if (o_nowa[d]) begin
                    cnt_addr[d] <= cnt_addr[d] + 13'd1;
                    cnt_full[d] <= (({1'b0, cnt_addr[d]} + 14'd1) == cnt_n[d]);
                end
            end
        end
    end

    assign bus0.start        = start;       assign bus1.start        = start;
    assign bus0.ile_probek   = ile_probek;  assign bus1.ile_probek   = ile_probek;
    assign bus0.ile_wsp      = ile_wsp;     assign bus1.ile_wsp      = ile_wsp;
    assign bus0.licznik_full = cnt_full[0]; assign bus1.licznik_full = cnt_full[1];
    assign bus0.A_probki_FIR = cnt_addr[0]; assign bus1.A_probki_FIR = cnt_addr[1];
`ifdef FIR_IRQ_EN
    assign bus0.irq_ack      = irq_ack;     assign bus1.irq_ack      = irq_ack;
    logic o_irq[2];
    assign o_irq[0] = bus0.irq;             assign o_irq[1] = bus1.irq;
`endif

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    // Run length, LOAD through DONE inclusive.
    function automatic int model_len(input int n, input int w, input int l);
        if (n == 0 || w == 0) return 2;
        return 2 + n * (w + l + 4);
    endfunction

    // Offset (LOAD = 0) of the WRITE cycle of sample i: LOAD, i full samples,
    // then CLR, w MAC cycles and l WAIT cycles.
    function automatic int exp_wr_cyc(input int i, input int w, input int l);
        return 1 + i * (w + l + 4) + 1 + w + l;
    endfunction

    // Run monitor, sampled on the falling edge. Per-run counters restart at
    // each LOAD; done_total and load_total never restart.
    int run_cyc [2];
    int mon_w   [2];
    int busy_cnt[2];
    int mac_cnt [2];
    int mac_bad [2];
    int wr_cnt  [2];
    int wr_bad  [2];
    int nowa_cnt[2];
    int clr_cnt [2];
    int rl_cnt  [2];
    int done_cyc[2];
    int done_total[2] = '{0, 0};
    int load_total[2] = '{0, 0};

    function automatic int cur_cyc(input int d);
        return o_zap[d] ? 0 : run_cyc[d] + 1;
    endfunction

    always @(negedge clk_b) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                run_cyc[d]  <= cur_cyc(d);
                if (o_zap[d]) begin
                    mon_w[d]      <= int'(ile_wsp);
                    load_total[d] <= load_total[d] + 1;
                end
                busy_cnt[d] <= (o_zap[d] ? 0 : busy_cnt[d]) + (o_busy[d] ? 1 : 0);
                mac_cnt[d]  <= (o_zap[d] ? 0 : mac_cnt[d])  + (o_en[d]   ? 1 : 0);
                wr_cnt[d]   <= (o_zap[d] ? 0 : wr_cnt[d])   + (o_we[d]   ? 1 : 0);
                nowa_cnt[d] <= (o_zap[d] ? 0 : nowa_cnt[d]) + (o_nowa[d] ? 1 : 0);
                clr_cnt[d]  <= (o_zap[d] ? 0 : clr_cnt[d])  + (o_clr[d]  ? 1 : 0);
                rl_cnt[d]   <= (o_zap[d] ? 0 : rl_cnt[d])   + (o_rl[d]   ? 1 : 0);
                mac_bad[d]  <= (o_zap[d] ? 0 : mac_bad[d]) +
                               ((o_en[d] && (o_zap[d] || mon_w[d] == 0 ||
                                 int'(o_awsp[d]) != (mac_cnt[d] % mon_w[d]))) ? 1 : 0);
                wr_bad[d]   <= (o_zap[d] ? 0 : wr_bad[d]) +
                               ((o_we[d] && (o_zap[d] || int'(o_awyn[d]) != wr_cnt[d] ||
                                 cur_cyc(d) != exp_wr_cyc(wr_cnt[d], mon_w[d], lat_of(d)))) ? 1 : 0);
                if (o_done[d]) begin
                    done_total[d] <= done_total[d] + 1;
                    done_cyc[d]   <= cur_cyc(d);
                end else if (o_zap[d]) begin
                    done_cyc[d]   <= -1;
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] strobes(input int d);
        return {o_zap[d], o_rl[d], o_nowa[d], o_clr[d], o_en[d], o_we[d], o_busy[d], o_done[d]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s strobes dut%0d", tag, d), strobes(d), 0);
            check($sformatf("%s A_wsp dut%0d", tag, d), o_awsp[d], 0);
            check($sformatf("%s A_wyn dut%0d", tag, d), o_awyn[d], 0);
`ifdef FIR_IRQ_EN
            check($sformatf("%s irq dut%0d", tag, d), o_irq[d], 0);
`endif
        end
    endtask

    task automatic pulse_start();
        @(posedge clk_b); #1 start = 1'b1;
        @(posedge clk_b); #1 start = 1'b0;
    endtask

    // One run on both instances; len_a/len_b are the expected run lengths for
    // MAC_LAT=2 and MAC_LAT=0. With wiggle set, ile_wsp is changed once LOAD
    // has passed, which must not affect the run.
    task automatic do_run(input string tag, input int n, input int w,
                          input int len_a, input int len_b, input bit wiggle);
        int d0;
        int d1;
        int waited;
        int n_eff;
        n_eff      = (n == 0 || w == 0) ? 0 : n;
        ile_probek = 14'(n);
        ile_wsp    = WSP_W'(w);
        d0 = done_total[0];
        d1 = done_total[1];
        pulse_start();
        @(posedge clk_b); #1;
        if (wiggle) ile_wsp = ~ile_wsp;
        waited = 0;
        while (!(done_total[0] > d0 && done_total[1] > d1) && waited < 600) begin
            @(negedge clk_b); #1;
            waited++;
        end
        check({tag, " finished in budget"}, (done_total[0] > d0 && done_total[1] > d1) ? 1 : 0, 1);
        for (int d = 0; d < 2; d++) begin
            int exp_len;
            exp_len = (d == 0) ? len_a : len_b;
            check($sformatf("%s run length dut%0d", tag, d), done_cyc[d] + 1, exp_len);
            check($sformatf("%s busy cycles dut%0d", tag, d), busy_cnt[d], exp_len);
            check($sformatf("%s reset_licznik dut%0d", tag, d), rl_cnt[d], 1);
            check($sformatf("%s mac_clr count dut%0d", tag, d), clr_cnt[d], n_eff);
            check($sformatf("%s mac_en count dut%0d", tag, d), mac_cnt[d], n_eff * w);
            check($sformatf("%s A_wsp order errors dut%0d", tag, d), mac_bad[d], 0);
            check($sformatf("%s writes dut%0d", tag, d), wr_cnt[d], n_eff);
            check($sformatf("%s write addr/time errors dut%0d", tag, d), wr_bad[d], 0);
            check($sformatf("%s nowa_probka count dut%0d", tag, d), nowa_cnt[d], n_eff);
        end
    endtask

    typedef struct {
        int n;
        int w;
        int len_a;
        int len_b;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lt0;
        int lt1;
        int dt0;
        int dt1;
        int waited;
        int n;
        int w;

        // {samples, coefficients, run length MAC_LAT=2, run length MAC_LAT=0}
        vecs[0] = '{4, 3, 38, 30};
        vecs[1] = '{3, 2, 26, 20};  // follows a run that left licznik_full=1
        vecs[2] = '{1, 1,  9,  7};
        vecs[3] = '{0, 5,  2,  2};
        vecs[4] = '{3, 0,  2,  2};
        vecs[5] = '{2, 5, 24, 20};
        vecs[6] = '{1, 6, 14, 12};

        // Reset state.
        repeat (3) @(posedge clk_b);
        @(negedge clk_b); #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk_b);

        // Table-driven runs, back to back.
        for (int i = 0; i < 7; i++) begin
            do_run($sformatf("vec%0d", i), vecs[i].n, vecs[i].w,
                   vecs[i].len_a, vecs[i].len_b, (i % 2) == 1);
        end

        // start while busy, then reset in the middle of WAIT.
        ile_probek = 14'd3;
        ile_wsp    = WSP_W'(4);
        lt0 = load_total[0];
        lt1 = load_total[1];
        dt0 = done_total[0];
        dt1 = done_total[1];
        pulse_start();
        waited = 0;
        while (!o_en[0] && waited < 20) begin
            @(negedge clk_b); #1;
            waited++;
        end
        check("midrun reached MAC", o_en[0], 1);
        pulse_start();
        waited = 0;
        while (o_en[0] && waited < 20) begin
            @(negedge clk_b); #1;
            waited++;
        end
        check("midrun reached WAIT", {o_busy[0], o_en[0], o_we[0]}, 3'b100);
        check("start while busy ignored dut0", load_total[0], lt0 + 1);
        check("start while busy ignored dut1", load_total[1], lt1 + 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun reset");
        repeat (2) @(negedge clk_b);
        rst_n = 1'b1;
        repeat (40) @(negedge clk_b);
        #1;
        check("no done after reset dut0", done_total[0], dt0);
        check("no done after reset dut1", done_total[1], dt1);
        check("no queued start dut0", load_total[0], lt0 + 1);
        check("idle after reset dut0", strobes(0), 0);
        check("idle after reset dut1", strobes(1), 0);

`ifdef FIR_IRQ_EN
        // irq is sticky from the earlier completed run.
        check("irq sticky dut0", o_irq[0], 1);
        check("irq sticky dut1", o_irq[1], 1);
        @(posedge clk_b); #1 irq_ack = 1'b1;
        @(posedge clk_b); #1 irq_ack = 1'b0;
        check("irq cleared dut0", o_irq[0], 0);
        check("irq cleared dut1", o_irq[1], 0);
        // Acknowledge held while done fires: set wins on dut0; dut1 finished
        // earlier and has been acknowledged since.
        irq_ack = 1'b1;
        do_run("irq", 2, 2, model_len(2, 2, LAT_A), model_len(2, 2, LAT_B), 1'b0);
        @(negedge clk_b); #1;
        irq_ack = 1'b0;
        check("irq set wins dut0", o_irq[0], 1);
        check("irq acked dut1", o_irq[1], 0);
        repeat (3) @(negedge clk_b);
        #1;
        check("irq holds dut0", o_irq[0], 1);
        @(posedge clk_b); #1 irq_ack = 1'b1;
        @(posedge clk_b); #1 irq_ack = 1'b0;
        check("irq ack dut0", o_irq[0], 0);
`endif

        // Randomised runs against the run-length model.
        for (int r = 0; r < 12; r++) begin
            n = int'($urandom_range(0, 5));
            w = int'($urandom_range(1, 8));
            repeat (int'($urandom_range(0, 3))) @(posedge clk_b);
            do_run($sformatf("rnd%0d n=%0d w=%0d", r, n, w), n, w,
                   model_len(n, w, LAT_A), model_len(n, w, LAT_B), ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
